prescaled_updown_counter: RTL and testbench
===========================================

PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 24, as the count width in bits.
REQ-002 The block SHALL take parameter DIV_WIDTH, default 6, as the prescaler divisor width.
REQ-003 The block SHALL take parameter MODULUS, default 2**24, as the number of count states; legal range is 2..2**WIDTH.
REQ-004 Port MAX10_CLK1_50, input, 1 bit, SHALL be the single clock; every register updates on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-006 Port divideby, input, DIV_WIDTH bits, SHALL be the prescaler divisor.
REQ-007 Port enable, input, 1 bit, SHALL gate both prescaler and count advance.
REQ-008 Port up, input, 1 bit, SHALL select direction: 1 increments, 0 decrements.
REQ-009 Port free_run, input, 1 bit, SHALL select mode: 1 wraps, 0 is one-shot (saturate and stop).
REQ-010 Port load, input, 1 bit, SHALL request a synchronous load.
REQ-011 Port load_value, input, WIDTH bits, SHALL be the value to load.
REQ-012 Port count, output, WIDTH bits, SHALL be the current count, registered.
REQ-013 Port tick, output, 1 bit, SHALL be a one-cycle pulse on each prescaler advance, registered.
REQ-014 Port done, output, 1 bit, SHALL be the sticky one-shot terminal flag, registered.
REQ-015 Port div_zero, output, 1 bit, SHALL be high while divideby == 0, combinational.

Function
REQ-016 The prescaler SHALL count 0..divideby-1 while enable=1 and divideby!=0, and return to 0 after reaching divideby-1 or any higher value.
REQ-017 On a clock where the prescaler is at or above divideby-1, tick SHALL be 1 on the following cycle, and count SHALL advance on that same edge.
REQ-018 With divideby=1, the count SHALL advance every enabled clock.
REQ-019 With divideby=0, the prescaler and count SHALL hold, tick SHALL stay 0, and div_zero SHALL be 1.
REQ-020 With enable=0, prescaler, count and done SHALL hold and tick SHALL be 0; the prescaler resumes from its held value.
REQ-021 On an up advance, count SHALL become count+1, and MODULUS-1 SHALL wrap to 0 when free_run=1.
REQ-022 On a down advance, count SHALL become count-1, and 0 SHALL wrap to MODULUS-1 when free_run=1.
REQ-023 With free_run=0, an advance from the terminal value (MODULUS-1 if up, 0 if down) SHALL leave count unchanged and set done=1.
REQ-024 While done=1, count SHALL not advance, regardless of up changes.
REQ-025 The prescaler SHALL keep running while done=1.
REQ-026 load=1 SHALL override enable and divideby.
REQ-027 On load=1, count SHALL become load_value modulo MODULUS, the prescaler 0, done 0, and tick 0 in the next cycle.
REQ-028 Changing free_run from 0 to 1 SHALL clear done on the next clock.
REQ-029 All arithmetic SHALL be unsigned and WIDTH bits; there SHALL be no intermediate overflow beyond MODULUS.

Reset
REQ-030 reset=1 at a rising edge SHALL set count=0, prescaler=0, tick=0 and done=0.
REQ-031 Reset SHALL take priority over load and enable, including mid-count and mid-prescale.
REQ-032 The first advance after reset is released SHALL occur divideby enabled clocks later.

Structure
REQ-033 Package counter_pkg SHALL hold the default WIDTH/DIV_WIDTH/MODULUS constants and the direction/mode encodings.
REQ-034 The prescaler SHALL be a sub-module tick_prescaler (inputs clk, reset, enable, clear, divideby; output adv).
REQ-035 Count and done logic SHALL reside in the top module.

Verification
REQ-036 Reset, then divideby=3, up=1, free_run=1, enable=1 for 9 clocks -> count 0,0,1,1,1,2,2,2,3 and tick high on clocks 3, 6 and 9.
REQ-037 Drop enable for 7 clocks with count=2 -> count stays 2, tick stays 0, and the prescaler resumes where it stopped.
REQ-038 Set divideby=0 -> div_zero=1 and count frozen; then divideby=2 -> advance every 2 clocks.
REQ-039 Use MODULUS=10, up=0, free_run=1, count=1, divideby=1 -> count 0, 9, 8; with free_run=0 from count=1 -> 0, 0 with done=1, held.
REQ-040 Assert load=1 with load_value=7 while done=1 -> count=7 and done=0 next cycle; assert reset together with load -> count=0.
REQ-041 Use WIDTH=24, up=1, free_run=1, load 0xFFFFFE, divideby=1 -> count 0xFFFFFF, then 0x000000.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and encodings for the prescaled up/down counter.
package counter_pkg;

    localparam int     DEFAULT_WIDTH     = 24;
    localparam int     DEFAULT_DIV_WIDTH = 6;
    localparam longint DEFAULT_MODULUS   = longint'(1) << DEFAULT_WIDTH;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_ONE_SHOT = 1'b0,
        MODE_FREE_RUN = 1'b1
    } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable divider: asserts adv for one cycle every divideby enabled clocks.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] divideby,
    output logic                 adv
);

    logic [DIV_WIDTH-1:0] phase_q;
    logic [DIV_WIDTH-1:0] phase_d;
    logic                 running;

    always_comb begin
        running = enable && (divideby != '0) && !clear;
        // ">=" rather than "==" so a divisor lowered mid-count still recovers at once.
        adv     = running && (phase_q >= divideby - DIV_WIDTH'(1));
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (running) begin
            phase_d = adv ? '0 : phase_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Modulo-N up/down counter advanced by a programmable prescaler, with
// free-running or one-shot (saturating, sticky done) behaviour and synchronous load.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH     = DEFAULT_WIDTH,
    parameter int     DIV_WIDTH = DEFAULT_DIV_WIDTH,
    parameter longint MODULUS   = DEFAULT_MODULUS
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divideby,
    input  logic                 enable,
    input  logic                 up,
    input  logic                 free_run,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    output logic [WIDTH-1:0]     count,
    output logic                 tick,
    output logic                 done,
    output logic                 div_zero
);

    localparam logic [WIDTH-1:0] TERMINAL_UP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             free_run_q, free_run_d;
    logic             adv;
    logic [WIDTH-1:0] load_wrapped;
    dir_e             dir;
    mode_e            mode;

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk      (MAX10_CLK1_50),
        .reset    (reset),
        .enable   (enable),
        .clear    (load),
        .divideby (divideby),
        .adv      (adv)
    );

    // A full-range modulus needs no reduction; otherwise fold the load value into range.
    generate
        if (MODULUS == (longint'(1) << WIDTH)) begin : g_full_range
            assign load_wrapped = load_value;
        end else begin : g_partial_range
            localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
            assign load_wrapped = WIDTH'({1'b0, load_value} % MOD_EXT);
        end
    endgenerate

    assign dir  = dir_e'(up);
    assign mode = mode_e'(free_run);

    always_comb begin
        count_d    = count_q;
        done_d     = done_q;
        tick_d     = adv;
        free_run_d = free_run;
        if (load) begin
            count_d = load_wrapped;
            done_d  = 1'b0;
            tick_d  = 1'b0;
        end else begin
            if (adv && !done_q) begin
                if (dir == DIR_UP) begin
                    if (count_q == TERMINAL_UP) begin
                        if (mode == MODE_FREE_RUN) count_d = '0;
                        else                       done_d  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        if (mode == MODE_FREE_RUN) count_d = TERMINAL_UP;
                        else                       done_d  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            // Switching into free-run releases a saturated one-shot, even while disabled.
            if (free_run && !free_run_q) done_d = 1'b0;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            count_q    <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            free_run_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            free_run_q <= free_run_d;
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign done     = done_q;
    assign div_zero = (divideby == '0);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Scoreboard bench: two counters (full-range and modulo-10) share stimulus and
// are checked every cycle against a behavioural model of the counting rules.
module tb_prescaled_updown_counter;

    localparam int     W     = 24;
    localparam int     DW    = 6;
    localparam longint MOD_A = longint'(1) << W;
    localparam longint MOD_B = 10;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, up, free_run, load;
    logic [DW-1:0] divideby;
    logic [W-1:0]  load_value;
    logic [W-1:0]  count_a, count_b;
    logic          tick_a, tick_b, done_a, done_b, dz_a, dz_b;

    prescaled_updown_counter #(.WIDTH(W), .DIV_WIDTH(DW), .MODULUS(MOD_A)) u_dut_a (
        .MAX10_CLK1_50 (clk),      .reset      (reset),
        .divideby      (divideby), .enable     (enable),
        .up            (up),       .free_run   (free_run),
        .load          (load),     .load_value (load_value),
        .count         (count_a),  .tick       (tick_a),
        .done          (done_a),   .div_zero   (dz_a)
    );

    prescaled_updown_counter #(.WIDTH(W), .DIV_WIDTH(DW), .MODULUS(MOD_B)) u_dut_b (
        .MAX10_CLK1_50 (clk),      .reset      (reset),
        .divideby      (divideby), .enable     (enable),
        .up            (up),       .free_run   (free_run),
        .load          (load),     .load_value (load_value),
        .count         (count_b),  .tick       (tick_b),
        .done          (done_b),   .div_zero   (dz_b)
    );

    // Model state: the count as a plain number, plus how many enabled clocks
    // have elapsed since the last prescaler advance.
    typedef struct {
        longint count;
        bit     tick;
        bit     done;
        int     since_adv;
        bit     prev_fr;
    } model_t;

    typedef struct {
        longint count_a;
        bit     tick_a;
        bit     done_a;
        longint count_b;
        bit     tick_b;
        bit     done_b;
        bit     div_zero;
        int     cyc;
    } exp_t;

    model_t st_a, st_b;
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc_no   = 0;

    function automatic model_t model_step(input model_t s, input longint modulus);
        model_t n;
        bit     adv;
        n = s;
        if (reset) begin
            n.count = 0; n.tick = 0; n.done = 0; n.since_adv = 0; n.prev_fr = 0;
            return n;
        end
        n.prev_fr = free_run;
        if (load) begin
            n.count = longint'(load_value) % modulus;
            n.since_adv = 0; n.done = 0; n.tick = 0;
            return n;
        end
        adv = enable && (divideby != 0) && (s.since_adv + 1 >= int'(divideby));
        if (enable && divideby != 0) n.since_adv = adv ? 0 : s.since_adv + 1;
        n.tick = adv;
        if (adv && !s.done) begin
            if (up) begin
                if (s.count == modulus - 1) begin
                    if (free_run) n.count = 0; else n.done = 1;
                end else n.count = s.count + 1;
            end else begin
                if (s.count == 0) begin
                    if (free_run) n.count = modulus - 1; else n.done = 1;
                end else n.count = s.count - 1;
            end
        end
        if (free_run && !s.prev_fr) n.done = 0;
        return n;
    endfunction

    // Apply the current inputs for n clocks, queueing the expected response of each.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            st_a = model_step(st_a, MOD_A);
            st_b = model_step(st_b, MOD_B);
            e.count_a = st_a.count; e.tick_a = st_a.tick; e.done_a = st_a.done;
            e.count_b = st_b.count; e.tick_b = st_b.tick; e.done_b = st_b.done;
            e.div_zero = (divideby == 0);
            e.cyc = cyc_no;
            cyc_no++;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input longint act, input longint req, input int cyc);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            $display("cyc %0d a: count=%h tick=%b done=%b | b: count=%0d tick=%b done=%b | dz=%b",
                     mon_e.cyc, count_a, tick_a, done_a, count_b, tick_b, done_b, dz_a);
            check("count_a",  longint'(count_a), mon_e.count_a,           mon_e.cyc);
            check("tick_a",   longint'(tick_a),  longint'(mon_e.tick_a),  mon_e.cyc);
            check("done_a",   longint'(done_a),  longint'(mon_e.done_a),  mon_e.cyc);
            check("count_b",  longint'(count_b), mon_e.count_b,           mon_e.cyc);
            check("tick_b",   longint'(tick_b),  longint'(mon_e.tick_b),  mon_e.cyc);
            check("done_b",   longint'(done_b),  longint'(mon_e.done_b),  mon_e.cyc);
            check("div_zero", longint'({dz_a, dz_b}), mon_e.div_zero ? 3 : 0, mon_e.cyc);
        end
    end

    initial begin
        st_a = '{0, 0, 0, 0, 0};
        st_b = '{0, 0, 0, 0, 0};
        reset = 1'b1; enable = 1'b0; up = 1'b1; free_run = 1'b1; load = 1'b0;
        divideby = 6'd3; load_value = '0;
        @(negedge clk);
        step(2);

        // Divide by three, counting up from reset.
        reset = 1'b0; enable = 1'b1; step(9);

        // Pause with count 2 mid-prescale, then resume.
        load = 1'b1; load_value = 24'd2; step(1); load = 1'b0;
        step(1);
        enable = 1'b0; step(7);
        enable = 1'b1; step(4);

        // Zero divisor freezes everything; divisor 2 then advances every other clock.
        divideby = 6'd0; step(4);
        divideby = 6'd2; step(6);

        // Down count across zero: wrapping, then one-shot saturation.
        divideby = 6'd1; up = 1'b0;
        load = 1'b1; load_value = 24'd1; step(1); load = 1'b0;
        step(3);
        free_run = 1'b0;
        load = 1'b1; load_value = 24'd1; step(1); load = 1'b0;
        step(4);

        // Load while done, then reset together with load.
        load = 1'b1; load_value = 24'd7; step(1); load = 1'b0;
        step(2);
        reset = 1'b1; load = 1'b1; step(1);
        reset = 1'b0; load = 1'b0; step(2);

        // Saturate at zero, flip direction while done, then release via free-run.
        free_run = 1'b0; up = 1'b0; step(3);
        up = 1'b1; step(2);
        free_run = 1'b1; step(3);

        // Top-of-range wrap on the full-width counter.
        up = 1'b1; free_run = 1'b1; divideby = 6'd1;
        load = 1'b1; load_value = 24'hFFFFFE; step(1); load = 1'b0;
        step(3);

        repeat (450) begin
            reset  = ($urandom_range(0, 59) == 0);
            load   = ($urandom_range(0, 19) == 0);
            enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 7) == 0)  up = ~up;
            if ($urandom_range(0, 15) == 0) free_run = ~free_run;
            if ($urandom_range(0, 9) == 0)
                divideby = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(4, 63))
                                                       : DW'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       load_value = W'($urandom);
                1:       load_value = W'($urandom_range(0, 12));
                2:       load_value = 24'hFFFFFF - W'($urandom_range(0, 3));
                default: load_value = W'($urandom_range(0, 1000));
            endcase
            step(1);
        end

        reset = 1'b0; load = 1'b0;
        @(posedge clk);
        #3;
        check("drain", longint'(exp_q.size()), 0, cyc_no);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
